// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type and data width for the UART byte receiver
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

   localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - first-word fall-through byte FIFO with a registered head
// A pushed byte reaches dout/valid one cycle after the write, so valid tracks the pre-push write pointer.
module byte_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic [UART_DATA_BITS-1:0] din,
   output logic                      full,
   input  logic                      pop,
   output logic [UART_DATA_BITS-1:0] dout,
   output logic                      valid
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
   logic [AW:0]               wr_ptr_q, wr_ptr_d;
   logic [AW:0]               rd_ptr_q, rd_ptr_d;
   logic [UART_DATA_BITS-1:0] dout_q, dout_d;
   logic                      valid_q, valid_d;
   logic                      pop_fire;
   logic                      push_fire;

   assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop_fire  = pop && valid_q;
   assign push_fire = push && (!full || pop_fire);
   assign dout      = dout_q;
   assign valid     = valid_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_fire)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      valid_d = (rd_ptr_d != wr_ptr_q);
      dout_d  = valid_d ? mem_q[rd_ptr_d[AW-1:0]] : dout_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         dout_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_fire) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 serial receiver feeding a byte FIFO stream
// Line is synchronized, mid-bit sampled by the FSM, and good bytes are queued for the consumer.
module uart_byte_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rx_serial,
   output logic [UART_DATA_BITS-1:0] rx_frame,
   output logic                      rx_valid,
   input  logic                      rx_ready,
   output logic                      frame_err,
   output logic                      overflow
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [2:0]    IDX_LAST  = 3'(UART_DATA_BITS - 1);

   logic [1:0]                sync_q;
   logic                      rxs;
   uart_state_t               state_q, state_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [2:0]                idx_q, idx_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic                      push_q, push_d;
   logic                      ferr_q, ferr_d;
   logic                      ovf_q, ovf_d;
   logic                      fifo_full;

   assign rxs       = sync_q[1];
   assign frame_err = ferr_q;
   assign overflow  = ovf_q;
   // A pop in the same cycle frees the slot the pending push needs.
   assign ovf_d     = push_q && fifo_full && !(rx_valid && rx_ready);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_ONE;
      idx_d   = idx_q;
      shift_d = shift_q;
      push_d  = 1'b0;
      ferr_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rxs) begin
               state_d = START;
               idx_d   = '0;
            end
         end
         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               state_d = rxs ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d          = '0;
               shift_d[idx_q] = rxs;
               if (idx_q == IDX_LAST) state_d = STOP;
               else                   idx_d   = idx_q + 3'd1;
            end
         end
         STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
               push_d  = rxs;
               ferr_d  = !rxs;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q  <= 2'b11;
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         push_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], rx_serial};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         push_q  <= push_d;
         ferr_q  <= ferr_d;
         ovf_q   <= ovf_d;
      end
   end

   byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_q),
      .din   (shift_q),
      .full  (fifo_full),
      .pop   (rx_ready),
      .dout  (rx_frame),
      .valid (rx_valid)
   );

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb/tb_uart_byte_rx.sv - self-checking bench for uart_byte_rx
`timescale 1ns/1ps
module tb_uart_byte_rx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int HALF  = CPB / 2;
   // line fall -> rx_valid: 2 sync + 1 detect + half bit + 9 bit periods + push + FWFT register
   localparam int LAT   = 2 + 1 + HALF + 9 * CPB + 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx_serial = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_frame;
   logic       rx_valid, frame_err, overflow;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0] got_q[$];
   int         pop_cyc[$];
   int         rise_cyc[$];
   int         valid_n = 0, ferr_n = 0, ovf_n = 0;
   logic       prev_valid = 1'b0;

   uart_byte_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_serial (rx_serial),
      .rx_frame  (rx_frame),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_valid && !prev_valid) rise_cyc.push_back(cyc);
      prev_valid = rx_valid;
      if (rx_valid) valid_n++;
      if (rx_valid && rx_ready) begin
         got_q.push_back(rx_frame);
         pop_cyc.push_back(cyc);
      end
      if (frame_err) ferr_n++;
      if (overflow) ovf_n++;
   end

   task automatic idle(input int n);
      rx_serial = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop, output int k);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      k = cyc;
      for (int i = 0; i < 10; i++) begin
         rx_serial = bits[i];
         repeat (CPB) @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
      checks++; if (rx_frame !== 8'h00) begin errors++; $display("FAIL reset_frame: got %h expected 00", rx_frame); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
      rst = 1'b1;
      idle(4);
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b expected 0", rx_valid); end
   endtask

   task automatic test_single();
      int k, g0, r0, v0;
      rx_ready = 1'b1;
      g0 = got_q.size(); r0 = rise_cyc.size(); v0 = valid_n;
      send_byte(8'hA5, 1'b1, k);
      idle(10);
      checks++;
      if (got_q.size() != g0 + 1) begin errors++; $display("FAIL single_count: got %0d expected %0d", got_q.size() - g0, 1); end
      else if (got_q[g0] !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", got_q[g0]); end
      checks++;
      if (rise_cyc.size() != r0 + 1) begin errors++; $display("FAIL single_rise_count: got %0d expected 1", rise_cyc.size() - r0); end
      else if (rise_cyc[r0] != k + LAT) begin errors++; $display("FAIL single_latency: got %0d expected %0d", rise_cyc[r0] - k, LAT); end
      checks++; if (valid_n - v0 != 1) begin errors++; $display("FAIL single_valid_cycles: got %0d expected 1", valid_n - v0); end
   endtask

   task automatic test_frame();
      logic [63:0] frame;
      logic [7:0]  exp;
      int k, g0;
      frame = 64'h960f0173a7583362;
      rx_ready = 1'b1;
      g0 = got_q.size();
      for (int i = 0; i < 8; i++) send_byte(frame[63 - 8*i -: 8], 1'b1, k);
      idle(10);
      checks++;
      if (got_q.size() != g0 + 8) begin errors++; $display("FAIL frame_count: got %0d expected 8", got_q.size() - g0); end
      else begin
         for (int i = 0; i < 8; i++) begin
            exp = frame[63 - 8*i -: 8];
            checks++;
            if (got_q[g0 + i] !== exp) begin errors++; $display("FAIL frame_byte%0d: got %h expected %h", i, got_q[g0 + i], exp); end
         end
      end
   endtask

   task automatic test_frame_err();
      int k, g0, f0, v0;
      rx_ready = 1'b1;
      g0 = got_q.size(); f0 = ferr_n; v0 = valid_n;
      send_byte(8'h3C, 1'b0, k);
      idle(2 * CPB);
      checks++; if (ferr_n - f0 != 1) begin errors++; $display("FAIL ferr_pulse: got %0d cycles expected 1", ferr_n - f0); end
      checks++; if (valid_n - v0 != 0) begin errors++; $display("FAIL ferr_valid: got %0d valid cycles expected 0", valid_n - v0); end
      send_byte(8'h01, 1'b1, k);
      idle(10);
      checks++;
      if (got_q.size() != g0 + 1) begin errors++; $display("FAIL ferr_next_count: got %0d expected 1", got_q.size() - g0); end
      else if (got_q[g0] !== 8'h01) begin errors++; $display("FAIL ferr_next_data: got %h expected 01", got_q[g0]); end
      checks++; if (ferr_n - f0 != 1) begin errors++; $display("FAIL ferr_extra: got %0d expected 1", ferr_n - f0); end
   endtask

   task automatic test_overflow();
      logic [7:0] model_q[$];
      int k, g0, o0, exp_ovf;
      rx_ready = 1'b0;
      g0 = got_q.size(); o0 = ovf_n; exp_ovf = 0;
      for (int b = 8'h10; b <= 8'h14; b++) begin
         if (model_q.size() < DEPTH) model_q.push_back(8'(b));
         else exp_ovf++;
      end
      for (int b = 8'h10; b <= 8'h13; b++) send_byte(8'(b), 1'b1, k);
      idle(4);
      checks++; if (ovf_n - o0 != 0) begin errors++; $display("FAIL ovf_early: got %0d expected 0", ovf_n - o0); end
      send_byte(8'h14, 1'b1, k);
      idle(10);
      checks++; if (ovf_n - o0 != exp_ovf) begin errors++; $display("FAIL ovf_pulse: got %0d expected %0d", ovf_n - o0, exp_ovf); end
      checks++; if (rx_valid !== 1'b1 || rx_frame !== model_q[0]) begin errors++; $display("FAIL ovf_hold: got %b/%h expected 1/%h", rx_valid, rx_frame, model_q[0]); end
      rx_ready = 1'b1;
      idle(10);
      checks++;
      if (got_q.size() != g0 + model_q.size()) begin errors++; $display("FAIL ovf_drain_count: got %0d expected %0d", got_q.size() - g0, model_q.size()); end
      else begin
         for (int i = 0; i < model_q.size(); i++) begin
            checks++;
            if (got_q[g0 + i] !== model_q[i] || pop_cyc[g0 + i] != pop_cyc[g0] + i) begin
               errors++;
               $display("FAIL ovf_drain%0d: got %h at +%0d expected %h at +%0d", i, got_q[g0 + i], pop_cyc[g0 + i] - pop_cyc[g0], model_q[i], i);
            end
         end
      end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b expected 0", rx_valid); end
   endtask

   task automatic test_glitch();
      int k, g0, v0, f0, o0;
      logic [7:0] b;
      rx_ready = 1'b1;
      g0 = got_q.size(); v0 = valid_n; f0 = ferr_n; o0 = ovf_n;
      rx_serial = 1'b0;
      @(posedge clk);
      #1;
      idle(4 * CPB);
      checks++; if (valid_n != v0 || ferr_n != f0 || ovf_n != o0) begin errors++; $display("FAIL glitch_quiet: got v%0d f%0d o%0d expected 0 0 0", valid_n - v0, ferr_n - f0, ovf_n - o0); end
      b = 8'($urandom);
      send_byte(b, 1'b1, k);
      idle(10);
      checks++;
      if (got_q.size() != g0 + 1) begin errors++; $display("FAIL glitch_next_count: got %0d expected 1", got_q.size() - g0); end
      else if (got_q[g0] !== b) begin errors++; $display("FAIL glitch_next_data: got %h expected %h", got_q[g0], b); end
   endtask

   task automatic test_random();
      logic [7:0] exp_q[$];
      logic [7:0] b;
      logic       stop;
      int k, g0, f0, o0, bad;
      bit done;
      g0 = got_q.size(); f0 = ferr_n; o0 = ovf_n; bad = 0; done = 0;
      fork
         begin
            for (int n = 0; n < 20; n++) begin
               b = 8'($urandom);
               stop = ($urandom_range(0, 4) != 0);
               send_byte(b, stop, k);
               if (stop) begin
                  exp_q.push_back(b);
                  idle($urandom_range(0, 3));
               end else begin
                  bad++;
                  idle(2 * CPB + $urandom_range(0, 3));
               end
            end
            done = 1;
         end
         begin
            while (!done) begin
               rx_ready = 1'($urandom_range(0, 1));
               @(posedge clk);
               #1;
            end
         end
      join
      rx_ready = 1'b1;
      idle(20);
      checks++;
      if (got_q.size() != g0 + exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", got_q.size() - g0, exp_q.size()); end
      else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_q[g0 + i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte%0d: got %h expected %h", i, got_q[g0 + i], exp_q[i]); end
         end
      end
      checks++; if (ferr_n - f0 != bad) begin errors++; $display("FAIL rand_ferr: got %0d expected %0d", ferr_n - f0, bad); end
      checks++; if (ovf_n != o0) begin errors++; $display("FAIL rand_ovf: got %0d expected 0", ovf_n - o0); end
   endtask

   task automatic test_reset_mid();
      int k, g0, f0, o0;
      rx_ready = 1'b0;
      send_byte(8'($urandom), 1'b1, k);
      send_byte(8'($urandom), 1'b1, k);
      idle(4);
      checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL rstmid_queued: got %b expected 1", rx_valid); end
      fork
         send_byte(8'hFF, 1'b1, k);
         begin
            // lands while the receiver is on data bit 3
            repeat (19) @(posedge clk);
            #3;
            rst = 1'b0;
            #1;
            checks++; if (rx_valid !== 1'b0 || rx_frame !== 8'h00) begin errors++; $display("FAIL rstmid_clear: got %b/%h expected 0/00", rx_valid, rx_frame); end
            @(posedge clk);
            #1;
            rst = 1'b1;
         end
      join
      idle(4);
      g0 = got_q.size(); f0 = ferr_n; o0 = ovf_n;
      rx_ready = 1'b1;
      send_byte(8'h55, 1'b1, k);
      idle(10);
      checks++;
      if (got_q.size() != g0 + 1) begin errors++; $display("FAIL rstmid_count: got %0d expected 1", got_q.size() - g0); end
      else if (got_q[g0] !== 8'h55) begin errors++; $display("FAIL rstmid_data: got %h expected 55", got_q[g0]); end
      checks++; if (ferr_n != f0 || ovf_n != o0) begin errors++; $display("FAIL rstmid_flags: got f%0d o%0d expected 0 0", ferr_n - f0, ovf_n - o0); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_frame();
      test_frame_err();
      test_overflow();
      test_glitch();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
